uio_mem_bus_arbiter: RTL and testbench
======================================

// Module: uio_mem_bus_arbiter
// PURPOSE
//  Shares the 8-bit bidirectional uio pin bus of the tt_um top between the core's instruction-fetch
//  port and data port. Grants one requester at a time and serializes each 32-bit access as byte
//  phases: command, address LSB-first, then write data out or read data in. Drives uio_out/uio_oe
//  directly and sits between the Risco_5 core and the chip-level pins.
// PARAMETERS
//  ADDR_BYTES  3    address bytes sent per access (address width = 8*ADDR_BYTES)
//  TIMEOUT     255  max consecutive wait cycles per byte before abort; 0 disables timeout
// PORTS
//  clk        in   1             clock; single clock domain
//  rst_n      in   1             asynchronous active-low reset
//  ena        in   1             design selected; 0 blocks new grants only
//  i_req      in   1             instruction read request (level, held until i_ack)
//  i_addr     in   8*ADDR_BYTES  instruction address
//  i_rdata    out  32            instruction read data
//  i_ack      out  1             one-cycle completion pulse, instruction port
//  d_req      in   1             data request (level, held until d_ack)
//  d_we       in   1             1 = write, 0 = read
//  d_addr     in   8*ADDR_BYTES  data address
//  d_wdata    in   32            write data
//  d_rdata    out  32            data read data
//  d_ack      out  1             one-cycle completion pulse, data port
//  err        out  1             high with ack when the access timed out
//  bus_in     in   8             uio_in
//  bus_out    out  8             uio_out
//  bus_oe     out  8             uio_oe (0xFF drive, 0x00 receive)
//  bus_strobe out  1             byte-phase valid, routed to a uo_out bit
//  bus_ready  in   1             external byte accepted/provided, from a ui_in bit
// BEHAVIOUR
//  Reset: state IDLE, bus_out=0, bus_oe=0x00, bus_strobe=0, acks=0, err=0, rdata=0, last_grant=instr.
//  States: IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE.
//  IDLE: when ena=1 and any req, grant and latch addr/we/wdata; next state CMD. Both pending: grant
//    the port not granted last (round robin). ena=0 or no req: stay IDLE.
//  CMD: bus_oe=0xFF, strobe=1, bus_out={we,port,6'b0} (port 1=data; instr we=0). Advance on ready.
//  ADDR: ADDR_BYTES bytes LSB first, strobe=1, one byte per cycle with bus_ready=1.
//    Last byte accepted: write -> WDATA; read -> TURN.
//  WDATA: 4 bytes LSB first, strobe=1, oe=0xFF; after 4th accepted -> DONE.
//  TURN: exactly 1 cycle, bus_oe=0x00, strobe=0 (bus turnaround); -> RDATA.
//  RDATA: oe=0x00, strobe=1; capture bus_in on each cycle with bus_ready=1, LSB first; 4th -> DONE.
//  DONE: 1 cycle; oe=0x00, strobe=0; granted port's ack=1; its rdata updated this cycle (reads
//    only) and held until its next read completes; -> IDLE. Minimum one IDLE cycle between accesses.
//  Latency, bus_ready tied 1, ADDR_BYTES=3, req seen in IDLE at cycle 0: write ack at cycle 9,
//    read ack at cycle 10. Each low-ready cycle adds one.
//  Timeout: wait counter clears on every accepted byte and on state entry; increments while strobe=1
//    and bus_ready=0; reaching TIMEOUT -> DONE with err=1 (rdata not updated). TIMEOUT=0: never.
//  req dropped mid-access: access still completes and acks. ena dropped mid-access: completes.
//  Latched addr/wdata used throughout; later input changes ignored until next grant.
//  Async reset mid-access: immediate return to reset values, bus released (oe=0x00), no ack.
// TESTING
//  i_req, i_addr=0x123456, ready=1, bus_in=0xA0..0xA3 -> bytes 00,56,34,12; turn oe=00; i_ack cyc10, i_rdata=0xA3A2A1A0.
//  d_req we=1 addr=0x000010 wdata=0xDEADBEEF, ready=1 -> bus 0xC0,10,00,00,EF,BE,AD,DE; d_ack at cycle 9.
//  i_req and d_req both held, ready=1 -> grants alternate instr,data,instr,...; no ack overlap.
//  d_req write, bus_ready low 3 cycles on 2nd addr byte -> byte held stable, d_ack at cycle 12.
//  TIMEOUT=4, ready stuck 0 in RDATA -> DONE after 4 wait cycles, ack+err=1, rdata unchanged.
//  rst_n low during WDATA -> same-cycle bus_oe=0x00, strobe=0; no ack; after release, IDLE grants anew.

Source files
------------

// File: rtl/uio_mem_bus_arbiter.sv
// Arbitrates the shared 8-bit uio pin bus between the instruction-fetch and data ports.
// Each 32-bit access is sent as byte phases: command, address (LSB first), then write or read data.
module uio_mem_bus_arbiter #(
  parameter int ADDR_BYTES = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    i_req,
  input  logic [8*ADDR_BYTES-1:0] i_addr,
  output logic [31:0]             i_rdata,
  output logic                    i_ack,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [8*ADDR_BYTES-1:0] d_addr,
  input  logic [31:0]             d_wdata,
  output logic [31:0]             d_rdata,
  output logic                    d_ack,
  output logic                    err,
  input  logic [7:0]              bus_in,
  output logic [7:0]              bus_out,
  output logic [7:0]              bus_oe,
  output logic                    bus_strobe,
  input  logic                    bus_ready
);

  localparam int AW     = 8 * ADDR_BYTES;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE} state_e;

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant_data;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      byte_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      byte_cnt_q   <= byte_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign accept     = bus_strobe && bus_ready;
  assign grant_data = d_req && (!i_req || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    byte_cnt_d   = byte_cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (ena && (i_req || d_req)) begin
          port_d       = grant_data;
          last_grant_d = grant_data;
          we_d         = grant_data && d_we;
          addr_d       = grant_data ? d_addr : i_addr;
          wdata_d      = d_wdata;
          err_d        = 1'b0;
          byte_cnt_d   = '0;
          state_d      = CMD;
        end
      end
      CMD: begin
        if (accept) state_d = ADDR;
      end
      ADDR: begin
        if (accept) begin
          addr_d = addr_q >> 8;
          if (byte_cnt_q == ADDR_LAST) begin
            byte_cnt_d = '0;
            state_d    = we_q ? WDATA : TURN;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      WDATA: begin
        if (accept) begin
          wdata_d = wdata_q >> 8;
          if (byte_cnt_q == 3'd3) state_d = DONE;
          else byte_cnt_d = byte_cnt_q + 3'd1;
        end
      end
      TURN: begin
        byte_cnt_d = '0;
        state_d    = RDATA;
      end
      RDATA: begin
        if (accept) begin
          rbuf_d = {bus_in, rbuf_q[23:8]};
          if (byte_cnt_q == 3'd3) begin
            state_d = DONE;
            if (port_q) d_rdata_d = {bus_in, rbuf_q};
            else        i_rdata_d = {bus_in, rbuf_q};
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The wait counter only runs while a strobed byte is stalled; any accept or unstrobed cycle clears it.
    if (bus_strobe && !bus_ready) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    else                          wait_cnt_d = '0;

    if ((TIMEOUT != 0) && bus_strobe && !bus_ready && (wait_cnt_q == WAIT_LAST)) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    bus_out    = 8'h00;
    bus_oe     = 8'h00;
    bus_strobe = 1'b0;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    err        = 1'b0;
    case (state_q)
      CMD: begin
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        bus_out    = {we_q, port_q, 6'b0};
      end
      ADDR: begin
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        bus_out    = addr_q[7:0];
      end
      WDATA: begin
        bus_oe     = 8'hFF;
        bus_strobe = 1'b1;
        bus_out    = wdata_q[7:0];
      end
      RDATA: bus_strobe = 1'b1;
      DONE: begin
        i_ack = !port_q;
        d_ack = port_q;
        err   = err_q;
      end
      default: ;
    endcase
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_uio_mem_bus_arbiter.sv
// Scoreboard bench for uio_mem_bus_arbiter: stimulus queues expected bus bytes and acks,
// a bus-device process answers the byte phases and a monitor pops and compares.
module tb_uio_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        i_req;
  logic [23:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [23:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic [7:0]  bus_in = 8'h00;
  logic [7:0]  bus_out;
  logic [7:0]  bus_oe;
  logic        bus_strobe;
  logic        bus_ready = 1'b1;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } ack_t;

  logic [7:0] exp_bytes[$];
  logic [7:0] rd_bytes[$];
  ack_t       exp_acks[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_idx = -1;
  int stall_cnt = 0;
  int stall_used = 0;
  int byte_idx = 0;
  logic [31:0] i_model = 32'h0;
  logic [31:0] d_model = 32'h0;

  uio_mem_bus_arbiter #(.ADDR_BYTES(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_strobe(bus_strobe), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagUnexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // External byte device: decides bus_ready for the current phase and supplies read bytes.
  always @(negedge clk) begin
    if (!rst_n) begin
      byte_idx   = 0;
      stall_used = 0;
      bus_ready  = 1'b1;
    end else begin
      if (bus_strobe && byte_idx == stall_idx && stall_used < stall_cnt) begin
        bus_ready = 1'b0;
        stall_used++;
      end else begin
        bus_ready = 1'b1;
      end
      if (bus_strobe && bus_ready) begin
        if (bus_oe == 8'h00) bus_in = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'h00;
        byte_idx++;
      end
      if (i_ack || d_ack) begin
        byte_idx   = 0;
        stall_used = 0;
      end
    end
  end

  // Monitor: compares every driven byte and every completion against the scoreboard.
  always @(negedge clk) begin
    ack_t a;
    #1;
    if (rst_n) begin
      if (bus_strobe && bus_oe == 8'hFF) begin
        if (exp_bytes.size() == 0)  flagUnexpected("unexpected bus byte", {24'h0, bus_out});
        else if (bus_ready)         checkOutput("bus byte", {24'h0, bus_out}, {24'h0, exp_bytes.pop_front()});
        else                        checkOutput("stalled byte held", {24'h0, bus_out}, {24'h0, exp_bytes[0]});
      end
      if (i_ack || d_ack) begin
        if (exp_acks.size() == 0) begin
          flagUnexpected("unexpected ack", {30'h0, d_ack, i_ack});
        end else begin
          a = exp_acks.pop_front();
          checkOutput("i_ack", {31'h0, i_ack}, {31'h0, !a.port});
          checkOutput("d_ack", {31'h0, d_ack}, {31'h0, a.port});
          checkOutput("err", {31'h0, err}, {31'h0, a.err});
          if (a.port) checkOutput("d_rdata", d_rdata, a.rdata);
          else        checkOutput("i_rdata", i_rdata, a.rdata);
          if (a.cyc >= 0) checkOutput("ack cycle", 32'(cyc), 32'(a.cyc));
        end
      end else if (err) begin
        flagUnexpected("err without ack", {31'h0, err});
      end
    end
  end

  // Issues one access from an IDLE cycle; called at negedge+2 and returns in the following IDLE cycle.
  task automatic applyStimulus(input logic port, input logic we, input logic [23:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int stall_i, input int stall_n, input logic exp_err,
                               input int lat, input int hold_off, input int drop_at);
    ack_t a;
    int   k;
    exp_bytes.push_back({we, port, 6'b0});
    for (int b = 0; b < 3; b++) exp_bytes.push_back(addr[8*b +: 8]);
    if (we) begin
      for (int b = 0; b < 4; b++) exp_bytes.push_back(wdata[8*b +: 8]);
    end else if (!exp_err) begin
      for (int b = 0; b < 4; b++) rd_bytes.push_back(rdata[8*b +: 8]);
      if (port) d_model = rdata;
      else      i_model = rdata;
    end
    stall_idx = stall_i;
    stall_cnt = stall_n;
    if (port) begin
      d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_addr = addr;
    end
    if (hold_off > 0) begin
      ena = 1'b0;
      if (port) d_req = 1'b1; else i_req = 1'b1;
      for (int h = 0; h < hold_off; h++) begin
        @(negedge clk); #2;
        checkOutput("ena low blocks grant", {31'h0, bus_strobe}, 32'h0);
      end
    end
    ena = 1'b1;
    if (port) d_req = 1'b1; else i_req = 1'b1;
    a.port  = port;
    a.rdata = port ? d_model : i_model;
    a.err   = exp_err;
    a.cyc   = cyc + lat;
    exp_acks.push_back(a);
    k = 0;
    while (!(i_ack || d_ack) && k < 60) begin
      @(negedge clk); #2;
      k++;
      if (k == 3) begin
        if (port) begin
          d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
        end else begin
          i_addr = ~addr;
        end
      end
      if (drop_at > 0 && k == drop_at) begin
        d_req = 1'b0; i_req = 1'b0; ena = 1'b0;
      end
      if (!we && stall_n == 0 && k == 5) begin
        checkOutput("turnaround oe", {24'h0, bus_oe}, 32'h0);
        checkOutput("turnaround strobe", {31'h0, bus_strobe}, 32'h0);
      end
    end
    if (k >= 60) flagUnexpected("ack wait timed out", 32'(k));
    i_req = 1'b0; d_req = 1'b0; ena = 1'b1;
    stall_cnt = 0; stall_idx = -1;
    @(negedge clk); #2;
  endtask

  initial begin
    ack_t a;
    int   ni, nd, start, k;
    rst_n = 1'b0; ena = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 24'h0; d_addr = 24'h0; d_wdata = 32'h0;
    #12;
    checkOutput("reset bus_oe", {24'h0, bus_oe}, 32'h0);
    checkOutput("reset bus_out", {24'h0, bus_out}, 32'h0);
    checkOutput("reset strobe", {31'h0, bus_strobe}, 32'h0);
    checkOutput("reset acks", {30'h0, d_ack, i_ack}, 32'h0);
    checkOutput("reset i_rdata", i_rdata, 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #2;

    applyStimulus(1'b0, 1'b0, 24'h123456, 32'h0, 32'hA3A2A1A0, -1, 0, 1'b0, 10, 0, 0);
    applyStimulus(1'b1, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h0, -1, 0, 1'b0, 9, 0, 0);

    // Both ports held: last grant was data, so instruction wins first and grants alternate.
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h03); exp_bytes.push_back(8'h02); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'hC0);
    exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h44); exp_bytes.push_back(8'h33); exp_bytes.push_back(8'h22); exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h06); exp_bytes.push_back(8'h05); exp_bytes.push_back(8'h04);
    exp_bytes.push_back(8'hC0);
    exp_bytes.push_back(8'h30); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h88); exp_bytes.push_back(8'h77); exp_bytes.push_back(8'h66); exp_bytes.push_back(8'h55);
    rd_bytes.push_back(8'h10); rd_bytes.push_back(8'h20); rd_bytes.push_back(8'h30); rd_bytes.push_back(8'h40);
    rd_bytes.push_back(8'hAA); rd_bytes.push_back(8'hBB); rd_bytes.push_back(8'hCC); rd_bytes.push_back(8'hDD);
    start = cyc;
    a.port = 1'b0; a.rdata = 32'h40302010; a.err = 1'b0; a.cyc = start + 10; exp_acks.push_back(a);
    a.port = 1'b1; a.rdata = d_model;      a.err = 1'b0; a.cyc = start + 20; exp_acks.push_back(a);
    a.port = 1'b0; a.rdata = 32'hDDCCBBAA; a.err = 1'b0; a.cyc = start + 31; exp_acks.push_back(a);
    a.port = 1'b1; a.rdata = d_model;      a.err = 1'b0; a.cyc = start + 41; exp_acks.push_back(a);
    i_model = 32'hDDCCBBAA;
    i_addr = 24'h010203; d_addr = 24'h000020; d_we = 1'b1; d_wdata = 32'h11223344;
    i_req = 1'b1; d_req = 1'b1;
    ni = 0; nd = 0; k = 0;
    while ((ni < 2 || nd < 2) && k < 200) begin
      @(negedge clk); #2;
      k++;
      if (i_ack) begin
        ni++;
        if (ni == 1) i_addr = 24'h040506; else i_req = 1'b0;
      end
      if (d_ack) begin
        nd++;
        if (nd == 1) begin d_addr = 24'h000030; d_wdata = 32'h55667788; end
        else d_req = 1'b0;
      end
    end
    if (k >= 200) flagUnexpected("round robin timed out", 32'(k));
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk); #2;

    applyStimulus(1'b1, 1'b1, 24'h00C0DE, 32'h55AA0FF0, 32'h0, 2, 3, 1'b0, 12, 0, 0);
    applyStimulus(1'b0, 1'b0, 24'h000100, 32'h0, 32'h87654321, -1, 0, 1'b0, 10, 4, 0);
    applyStimulus(1'b1, 1'b0, 24'h000A0B, 32'h0, 32'h44332211, -1, 0, 1'b0, 10, 0, 4);
    applyStimulus(1'b0, 1'b0, 24'h0000FF, 32'h0, 32'h0, 4, 100, 1'b1, 10, 0, 0);

    // Reset while the second write-data byte is on the bus.
    exp_bytes.push_back(8'hC0);
    exp_bytes.push_back(8'hCD); exp_bytes.push_back(8'hAB); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h04); exp_bytes.push_back(8'h03);
    d_we = 1'b1; d_addr = 24'h00ABCD; d_wdata = 32'h01020304; d_req = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); #2; end
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("reset mid-access oe", {24'h0, bus_oe}, 32'h0);
    checkOutput("reset mid-access strobe", {31'h0, bus_strobe}, 32'h0);
    checkOutput("reset mid-access ack", {30'h0, d_ack, i_ack}, 32'h0);
    @(negedge clk); #2;
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    checkOutput("reset i_rdata cleared", i_rdata, 32'h0);
    i_model = 32'h0; d_model = 32'h0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #2;
    applyStimulus(1'b0, 1'b0, 24'h654321, 32'h0, 32'h0BADF00D, -1, 0, 1'b0, 10, 0, 0);

    for (int c = 0; c < 3; c++) begin @(negedge clk); #2; end
    checkOutput("bytes drained", 32'(exp_bytes.size()), 32'h0);
    checkOutput("acks drained", 32'(exp_acks.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
